// File: rtl/tile_sched_pkg.sv
// tile_sched_pkg: shared FSM states, layer-type codes and tile command layout
package tile_sched_pkg;
  localparam int CMD_KW = 11;
  localparam int CMD_RW = 8;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;
  localparam logic [1:0] LT_PW  = 2'd0;
  localparam logic [1:0] LT_DW  = 2'd1;
  localparam logic [1:0] LT_STD = 2'd2;
  localparam logic [1:0] LT_LIN = 2'd3;
  typedef struct packed {
    logic [CMD_KW-1:0] k_idx;
    logic [CMD_KW-1:0] d_idx;
    logic [CMD_KW-1:0] k_len;
    logic [CMD_KW-1:0] d_len;
    logic [CMD_RW-1:0] r_idx;
    logic [CMD_RW-1:0] r_len;
    logic              first_d;
    logic              last_d;
  } tile_cmd_t;
endpackage

// File: rtl/tile_scheduler_if.sv
// tile_scheduler_if: tile command handshake and completion between scheduler and tile engine
interface tile_scheduler_if;
  import tile_sched_pkg::*;
  logic      cmd_valid;
  logic      cmd_ready;
  tile_cmd_t cmd;
  logic      tile_done;
  modport master (output cmd_valid, cmd, input cmd_ready, tile_done);
  modport slave  (input cmd_valid, cmd, output cmd_ready, tile_done);
endinterface

// File: rtl/tile_span_calc.sv
// tile_span_calc: len = min(tile, total - idx) with zero tile treated as 1; last when the span reaches total
module tile_span_calc #(
  parameter int W  = 11,
  parameter int TW = 8
) (
  input  logic [W-1:0]  idx,
  input  logic [W-1:0]  total,
  input  logic [TW-1:0] tile,
  output logic [W-1:0]  len,
  output logic          last
);
  logic [W:0] t, rem;
  always_comb begin
    t    = (tile == '0) ? (W+1)'(1) : (W+1)'(tile);
    rem  = {1'b0, total} - {1'b0, idx};
    len  = (t < rem) ? t[W-1:0] : rem[W-1:0];
    last = t >= rem;
  end
endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks K/R/D tile loops issuing one command per tile; TILE_SCHED_PERF_EN adds stall/tile counters
module tile_scheduler import tile_sched_pkg::*; #(
  parameter int KW = CMD_KW,
  parameter int RW = CMD_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [1:0]    layer_type_i,
  input  logic [KW-1:0] in_D_i,
  input  logic [KW-1:0] out_K_i,
  input  logic [RW-1:0] out_R_i,
  input  logic [7:0]    tile_D_i,
  input  logic [7:0]    tile_K_i,
  input  logic [31:0]   tile_n_i,
  tile_scheduler_if.master cmd_if,
  output logic          busy_o,
  output logic          layer_done_o
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [31:0]   stall_cnt_o,
  output logic [31:0]   tile_cnt_o
`endif
);
  typedef struct packed {
    logic [1:0]    lt;
    logic [KW-1:0] in_d;
    logic [KW-1:0] out_k;
    logic [RW-1:0] out_r;
    logic [RW-1:0] tile_n;
    logic [7:0]    tile_d;
    logic [7:0]    tile_k;
  } cfg_t;
  state_t        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic [KW-1:0] k_q, k_d, d_q, d_d, k_len, d_len;
  logic [RW-1:0] r_q, r_d, r_len, tile_n_eff;
  logic          k_last, d_last, r_last, dw, degen;
  tile_cmd_t     cmd_c;
  tile_span_calc #(.W(KW), .TW(8))  u_k (.idx(k_q), .total(cfg_q.out_k), .tile(cfg_q.tile_k), .len(k_len), .last(k_last));
  tile_span_calc #(.W(KW), .TW(8))  u_d (.idx(d_q), .total(cfg_q.in_d),  .tile(cfg_q.tile_d), .len(d_len), .last(d_last));
  tile_span_calc #(.W(RW), .TW(RW)) u_r (.idx(r_q), .total(cfg_q.out_r), .tile(cfg_q.tile_n), .len(r_len), .last(r_last));
  assign dw         = cfg_q.lt == LT_DW;
  assign tile_n_eff = (tile_n_i == '0) ? RW'(1) : (|tile_n_i[31:RW]) ? out_R_i : tile_n_i[RW-1:0];
  assign degen      = out_K_i == '0 || out_R_i == '0 || (in_D_i == '0 && layer_type_i != LT_DW);
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    k_d     = k_q;
    d_d     = d_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        cfg_d   = '{lt: layer_type_i, in_d: in_D_i, out_k: out_K_i, out_r: out_R_i,
                    tile_n: tile_n_eff, tile_d: tile_D_i, tile_k: tile_K_i};
        k_d     = '0;
        d_d     = '0;
        r_d     = '0;
        state_d = degen ? S_DONE : S_ISSUE;
      end
      S_ISSUE: state_d = cmd_if.cmd_ready ? S_WAIT : S_ISSUE;
      S_WAIT:  state_d = cmd_if.tile_done ? S_NEXT : S_WAIT;
      S_NEXT: begin
        state_d = S_ISSUE;
        if (!dw && !d_last) d_d = d_q + d_len;
        else begin
          d_d = '0;
          if (!r_last) r_d = r_q + r_len;
          else begin
            r_d = '0;
            if (!k_last) k_d = k_q + k_len;
            else begin
              k_d     = '0;
              state_d = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // DW tiles use the K span for D and are always both first and last
  always_comb begin
    cmd_c = '0;
    if (state_q != S_IDLE) begin
      cmd_c.k_idx   = k_q;
      cmd_c.k_len   = k_len;
      cmd_c.r_idx   = r_q;
      cmd_c.r_len   = r_len;
      cmd_c.d_idx   = dw ? k_q : d_q;
      cmd_c.d_len   = dw ? k_len : d_len;
      cmd_c.first_d = dw || d_q == '0;
      cmd_c.last_d  = dw || d_last;
    end
  end
  assign cmd_if.cmd_valid = state_q == S_ISSUE;
  assign cmd_if.cmd       = cmd_c;
  assign busy_o           = state_q inside {S_ISSUE, S_WAIT, S_NEXT};
  assign layer_done_o     = state_q == S_DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      k_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      k_q     <= k_d;
      d_q     <= d_d;
      r_q     <= r_d;
    end
  end
`ifdef TILE_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d, tiles_q, tiles_d;
  always_comb begin
    stall_d = stall_q;
    tiles_d = tiles_q;
    if (state_q == S_IDLE && start_i) begin
      stall_d = '0;
      tiles_d = '0;
    end else begin
      if (cmd_if.cmd_valid && !cmd_if.cmd_ready && !(&stall_q)) stall_d = stall_q + 32'd1;
      if (cmd_if.cmd_valid && cmd_if.cmd_ready && !(&tiles_q)) tiles_d = tiles_q + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      tiles_q <= '0;
    end else begin
      stall_q <= stall_d;
      tiles_q <= tiles_d;
    end
  end
  assign stall_cnt_o = stall_q;
  assign tile_cnt_o  = tiles_q;
`endif
endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: scoreboard bench with an engine model; expected tile commands are hand-listed per layer
module tb_tile_scheduler;
  import tile_sched_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n, start, busy, layer_done;
  logic [1:0]  lt;
  logic [10:0] in_d, out_k;
  logic [7:0]  out_r, tile_d, tile_k;
  logic [31:0] tile_n;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0] stall_cnt, tile_cnt;
`endif
  tile_cmd_t exp_q[$];
  int checks = 0, errors = 0, acc_cnt = 0, done_cnt = 0;
  int stall_cycles = 0, lat = 1;
  bit spur = 1'b0;
  tile_scheduler_if bus();
  tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .layer_type_i(lt),
    .in_D_i(in_d), .out_K_i(out_k), .out_R_i(out_r),
    .tile_D_i(tile_d), .tile_K_i(tile_k), .tile_n_i(tile_n),
    .cmd_if(bus.master), .busy_o(busy), .layer_done_o(layer_done)
`ifdef TILE_SCHED_PERF_EN
    , .stall_cnt_o(stall_cnt), .tile_cnt_o(tile_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic tile_cmd_t mk(int k, int d, int r, int kl, int dl, int rl, bit f, bit l);
    tile_cmd_t c;
    c.k_idx = CMD_KW'(k);
    c.d_idx = CMD_KW'(d);
    c.r_idx = CMD_RW'(r);
    c.k_len = CMD_KW'(kl);
    c.d_len = CMD_KW'(dl);
    c.r_len = CMD_RW'(rl);
    c.first_d = f;
    c.last_d = l;
    return c;
  endfunction
  // scoreboard monitor: accepted commands pop, stalled commands must match the pending head
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cmd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got %0h with no command expected", bus.cmd);
        end else if (bus.cmd_ready) begin
          chk("cmd", 64'(bus.cmd), 64'(exp_q.pop_front()));
          acc_cnt++;
        end else chk("stall_stable", 64'(bus.cmd), 64'(exp_q[0]));
      end
      if (layer_done) done_cnt++;
    end
  end
  // engine model: optional stall before accept, optional spurious done while in ISSUE, done lat cycles after accept
  initial begin
    bus.cmd_ready = 1'b0;
    bus.tile_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.cmd_ready = (stall_cycles == 0);
      if (bus.cmd_valid && rst_n) begin
        if (stall_cycles > 0) begin
          bus.tile_done = spur;
          repeat (stall_cycles) begin @(posedge clk); #1; bus.tile_done = 1'b0; end
          bus.cmd_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.cmd_ready = (stall_cycles == 0);
        repeat (lat) begin @(posedge clk); #1; end
        bus.tile_done = 1'b1;
        @(posedge clk); #1;
        bus.tile_done = 1'b0;
      end
    end
  end
  task automatic set_layer(input logic [1:0] t, input int d, input int k, input int r,
                           input int td, input int tk, input logic [31:0] tn);
    lt = t; in_d = 11'(d); out_k = 11'(k); out_r = 8'(r);
    tile_d = 8'(td); tile_k = 8'(tk); tile_n = tn;
  endtask
  task automatic run_layer(input string name, input logic [1:0] t, input int d, input int k, input int r,
                           input int td, input int tk, input logic [31:0] tn, input bit degen);
    int base = done_cnt;
    int n = 0;
    set_layer(t, d, k, r, td, tk, tn);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_startup_valid"}, 64'(bus.cmd_valid), 64'(!degen));
    chk({name, "_startup_done"}, 64'(layer_done), 64'(degen));
    while (!layer_done && n < 3000) begin @(posedge clk); #1; n++; end
    chk({name, "_done_seen"}, 64'(layer_done), 64'(1));
    chk({name, "_busy_at_done"}, 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk({name, "_done_pulses"}, 64'(done_cnt - base), 64'(1));
    chk({name, "_done_single"}, 64'(layer_done), 64'(0));
    chk({name, "_leftover_cmds"}, 64'(exp_q.size()), 64'(0));
  endtask
  task automatic push_pw();
    for (int k = 0; k <= 32; k += 32)
      for (int r = 0; r <= 2; r += 2)
        for (int d = 0; d <= 32; d += 32)
          exp_q.push_back(mk(k, d, r, 32, 32, 2, d == 0, d == 32));
  endtask
  initial begin
    int base, n;
    rst_n = 1'b0;
    start = 1'b0;
    set_layer(LT_PW, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(bus.cmd_valid), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(layer_done), 64'(0));
    chk("reset_cmd", 64'(bus.cmd), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_pw();
    run_layer("pw_full", LT_PW, 64, 64, 4, 32, 32, 2, 0);
    exp_q.push_back(mk(0, 0, 0, 32, 10, 2, 1, 1));
    exp_q.push_back(mk(0, 0, 2, 32, 10, 1, 1, 1));
    exp_q.push_back(mk(32, 0, 0, 8, 10, 2, 1, 1));
    exp_q.push_back(mk(32, 0, 2, 8, 10, 1, 1, 1));
    run_layer("remainder", LT_PW, 10, 40, 3, 32, 32, 2, 0);
    exp_q.push_back(mk(0, 0, 0, 10, 10, 2, 1, 1));
    exp_q.push_back(mk(0, 0, 2, 10, 10, 1, 1, 1));
    exp_q.push_back(mk(10, 10, 0, 10, 10, 2, 1, 1));
    exp_q.push_back(mk(10, 10, 2, 10, 10, 1, 1, 1));
    run_layer("dw", LT_DW, 20, 20, 3, 7, 10, 2, 0);
    exp_q.push_back(mk(0, 0, 0, 8, 8, 5, 1, 1));
    run_layer("tile_n_sat", LT_LIN, 8, 8, 5, 8, 8, 256, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(i * 255, 0, 0, 255, 1, 1, 1, 1));
    exp_q.push_back(mk(2040, 0, 0, 7, 1, 1, 1, 1));
    run_layer("wide_k", LT_PW, 1, 2047, 1, 1, 255, 1, 0);
    exp_q.push_back(mk(0, 0, 0, 4, 4, 1, 1, 1));
    run_layer("dw_zero_d", LT_DW, 0, 4, 1, 5, 4, 1, 0);
    run_layer("zero_k", LT_PW, 64, 0, 4, 32, 32, 2, 1);
    run_layer("zero_d_std", LT_STD, 0, 8, 4, 32, 32, 2, 1);
    run_layer("zero_r_dw", LT_DW, 8, 8, 0, 32, 32, 2, 1);
    // backpressure with zero tile sizes, spurious done in ISSUE and a start while busy
    stall_cycles = 5;
    spur = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 1, 3, 1, 1, 0));
    exp_q.push_back(mk(0, 3, 0, 1, 2, 1, 0, 1));
    exp_q.push_back(mk(1, 0, 0, 1, 3, 1, 1, 0));
    exp_q.push_back(mk(1, 3, 0, 1, 2, 1, 0, 1));
    fork
      run_layer("backpressure", LT_STD, 5, 2, 1, 3, 0, 0, 0);
      begin
        repeat (10) @(posedge clk);
        #1;
        out_k = 11'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
`ifdef TILE_SCHED_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(20));
    chk("tile_cnt", 64'(tile_cnt), 64'(4));
`endif
    stall_cycles = 0;
    spur = 1'b0;
    // reset during WAIT of the third tile, then rerun from the first tile
    @(posedge clk); #1;
    lat = 4;
    base = acc_cnt;
    n = 0;
    push_pw();
    set_layer(LT_PW, 64, 64, 4, 32, 32, 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (acc_cnt < base + 3 && n < 500) begin @(posedge clk); #1; n++; end
    chk("rst_third_accept", 64'(acc_cnt - base), 64'(3));
    base = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_valid", 64'(bus.cmd_valid), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_done", 64'(layer_done), 64'(0));
    chk("rst_mid_cmd", 64'(bus.cmd), 64'(0));
    rst_n = 1'b1;
    exp_q.delete();
    lat = 1;
    repeat (8) begin @(posedge clk); #1; end
    chk("rst_no_done", 64'(done_cnt - base), 64'(0));
    push_pw();
    run_layer("after_reset", LT_PW, 64, 64, 4, 32, 32, 2, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
